axi_mem_arb: RTL

Parametrised, synthesizable multi-port AXI memory subordinate. Each of `CPU_NB` ports has bounded AW/W/AR queues with real backpressure. A round-robin arbiter serialises all ports onto one single-ported 64-bit memory array. It returns B/R responses with DECERR on out-of-range addresses, and keeps per-port transaction counters. It replaces the randomly-throttled behavioural memory between the CPU models and the shared memory in the multi-CPU AXI example.

---
 rtl/axi_mem_arb.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_arb.sv
// Multi-port AXI memory subordinate: per-port AW/W/AR queues, round-robin arbitration
// onto one single-ported 64-bit memory, B/R response slots and per-port counters.

package axi_mem_arb_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } axi_aw_t;

    typedef struct packed {
        logic [63:0] data;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
    } axi_ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
    } axi_r_t;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_DECERR = 2'd3;
endpackage

// Bounded FIFO whose ready is a registered "not full" flag.
module axi_mem_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ready, w_push;

    assign w_push  = i_valid && r_ready;
    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_cnt == '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !i_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (!w_push && i_pop)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module axi_mem_arb
    import axi_mem_arb_pkg::*;
#(
    parameter int CPU_NB        = 4,
    parameter int WORDS_PER_CPU = 1024,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  axi_aw_t     i_axi_s_aw      [CPU_NB],
    input  logic        i_axi_s_awvalid [CPU_NB],
    output logic        o_axi_s_awready [CPU_NB],
    input  axi_w_t      i_axi_s_w       [CPU_NB],
    input  logic        i_axi_s_wvalid  [CPU_NB],
    output logic        o_axi_s_wready  [CPU_NB],
    output axi_b_t      o_axi_s_b       [CPU_NB],
    output logic        o_axi_s_bvalid  [CPU_NB],
    input  logic        i_axi_s_bready  [CPU_NB],
    input  axi_ar_t     i_axi_s_ar      [CPU_NB],
    input  logic        i_axi_s_arvalid [CPU_NB],
    output logic        o_axi_s_arready [CPU_NB],
    output axi_r_t      o_axi_s_r       [CPU_NB],
    output logic        o_axi_s_rvalid  [CPU_NB],
    input  logic        i_axi_s_rready  [CPU_NB],
    output logic [31:0] o_wr_count      [CPU_NB],
    output logic [31:0] o_rd_count      [CPU_NB]
);
    localparam int          MEM_WORDS = CPU_NB * WORDS_PER_CPU;
    localparam int          IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int          PW        = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;
    localparam int unsigned NB        = CPU_NB;
    localparam logic [31:0] LIMIT     = 32'(MEM_WORDS);

    logic [63:0] r_mem [MEM_WORDS];

    axi_aw_t           w_aw_head [CPU_NB];
    axi_w_t            w_w_head  [CPU_NB];
    axi_ar_t           w_ar_head [CPU_NB];
    logic [CPU_NB-1:0] w_aw_empty, w_w_empty, w_ar_empty;
    logic [CPU_NB-1:0] w_aw_pop, w_w_pop, w_ar_pop;
    logic [CPU_NB-1:0] w_wr_req, w_rd_req;

    axi_b_t            r_b [CPU_NB];
    axi_r_t            r_r [CPU_NB];
    logic [CPU_NB-1:0] r_bvalid, r_rvalid, r_pref_wr;
    logic [31:0]       r_wr_cnt [CPU_NB];
    logic [31:0]       r_rd_cnt [CPU_NB];
    logic [PW-1:0]     r_rr;

    logic          w_gnt_vld, w_gnt_wr, w_in_range;
    logic [PW-1:0] w_gnt_port;
    logic [31:0]   w_gnt_addr;
    logic [IW-1:0] w_idx;

    for (genvar c = 0; c < CPU_NB; c++) begin : g_port
        axi_mem_arb_fifo #(.WIDTH($bits(axi_aw_t)), .DEPTH(QUEUE_DEPTH)) u_aw_q (
            .clk(clk), .rst(rst), .i_valid(i_axi_s_awvalid[c]), .o_ready(o_axi_s_awready[c]),
            .i_data(i_axi_s_aw[c]), .i_pop(w_aw_pop[c]), .o_data(w_aw_head[c]), .o_empty(w_aw_empty[c]));
        axi_mem_arb_fifo #(.WIDTH($bits(axi_w_t)), .DEPTH(QUEUE_DEPTH)) u_w_q (
            .clk(clk), .rst(rst), .i_valid(i_axi_s_wvalid[c]), .o_ready(o_axi_s_wready[c]),
            .i_data(i_axi_s_w[c]), .i_pop(w_w_pop[c]), .o_data(w_w_head[c]), .o_empty(w_w_empty[c]));
        axi_mem_arb_fifo #(.WIDTH($bits(axi_ar_t)), .DEPTH(QUEUE_DEPTH)) u_ar_q (
            .clk(clk), .rst(rst), .i_valid(i_axi_s_arvalid[c]), .o_ready(o_axi_s_arready[c]),
            .i_data(i_axi_s_ar[c]), .i_pop(w_ar_pop[c]), .o_data(w_ar_head[c]), .o_empty(w_ar_empty[c]));

        assign o_axi_s_b[c]      = r_b[c];
        assign o_axi_s_bvalid[c] = r_bvalid[c];
        assign o_axi_s_r[c]      = r_r[c];
        assign o_axi_s_rvalid[c] = r_rvalid[c];
        assign o_wr_count[c]     = r_wr_cnt[c];
        assign o_rd_count[c]     = r_rd_cnt[c];
    end

    // A pending response blocks further grants of that kind until it is accepted.
    assign w_wr_req = ~w_aw_empty & ~w_w_empty & ~r_bvalid;
    assign w_rd_req = ~w_ar_empty & ~r_rvalid;

    always_comb begin
        int unsigned k;
        k          = 0;
        w_gnt_vld  = 1'b0;
        w_gnt_wr   = 1'b0;
        w_gnt_port = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            k = 32'(r_rr) + i;
            if (k >= NB) k = k - NB;
            if (!w_gnt_vld && (w_wr_req[k] || w_rd_req[k])) begin
                w_gnt_vld  = 1'b1;
                w_gnt_port = PW'(k);
                w_gnt_wr   = w_wr_req[k] && (!w_rd_req[k] || r_pref_wr[k]);
            end
        end
    end

    always_comb begin
        w_aw_pop = '0;
        w_w_pop  = '0;
        w_ar_pop = '0;
        if (w_gnt_vld) begin
            if (w_gnt_wr) begin
                w_aw_pop[w_gnt_port] = 1'b1;
                w_w_pop[w_gnt_port]  = 1'b1;
            end else begin
                w_ar_pop[w_gnt_port] = 1'b1;
            end
        end
    end

    assign w_gnt_addr = w_gnt_wr ? w_aw_head[w_gnt_port].addr : w_ar_head[w_gnt_port].addr;
    assign w_in_range = (w_gnt_addr >> 3) < LIMIT;
    assign w_idx      = IW'(w_gnt_addr >> 3);

    always_ff @(posedge clk) begin
        if (w_gnt_vld && w_gnt_wr && w_in_range)
            r_mem[w_idx] <= w_w_head[w_gnt_port].data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < NB; c++) begin
                r_b[c]      <= '0;
                r_r[c]      <= '0;
                r_wr_cnt[c] <= '0;
                r_rd_cnt[c] <= '0;
            end
            r_bvalid  <= '0;
            r_rvalid  <= '0;
            r_pref_wr <= '1;
            r_rr      <= '0;
        end else begin
            for (int unsigned c = 0; c < NB; c++) begin
                if (r_bvalid[c] && i_axi_s_bready[c]) begin
                    r_bvalid[c] <= 1'b0;
                    if (r_wr_cnt[c] != '1) r_wr_cnt[c] <= r_wr_cnt[c] + 32'd1;
                end
                if (r_rvalid[c] && i_axi_s_rready[c]) begin
                    r_rvalid[c] <= 1'b0;
                    if (r_rd_cnt[c] != '1) r_rd_cnt[c] <= r_rd_cnt[c] + 32'd1;
                end
            end
            if (w_gnt_vld) begin
                r_rr <= (w_gnt_port == PW'(CPU_NB - 1)) ? '0 : w_gnt_port + PW'(1);
                r_pref_wr[w_gnt_port] <= ~r_pref_wr[w_gnt_port];
                if (w_gnt_wr) begin
                    r_b[w_gnt_port]      <= '{id: w_aw_head[w_gnt_port].id,
                                              resp: w_in_range ? RESP_OKAY : RESP_DECERR};
                    r_bvalid[w_gnt_port] <= 1'b1;
                end else begin
                    r_r[w_gnt_port]      <= '{id: w_ar_head[w_gnt_port].id,
                                              data: w_in_range ? r_mem[w_idx] : 64'd0,
                                              resp: w_in_range ? RESP_OKAY : RESP_DECERR};
                    r_rvalid[w_gnt_port] <= 1'b1;
                end
            end
        end
    end
endmodule
